// File: rtl/q_update_pkg.sv
// Shared definitions for the Q-routing datapath: word sizes, reward-packet layout,
// update-FSM encodings and Q8.8 saturation limits.
package q_update_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MEM_DEPTH  = 1024;
    localparam int PKT_WIDTH  = 80;

    localparam int NODE_ID_LSB    = 64;
    localparam int CLUSTER_ID_LSB = 48;
    localparam int REWARD_LSB     = 32;
    localparam int ACTION_LSB     = 16;
    localparam int MAXQ_LSB       = 0;

    // Field order matches the bit offsets above, most significant first.
    typedef struct packed {
        logic [15:0] node_id;
        logic [15:0] cluster_id;
        logic [15:0] reward;
        logic [15:0] action;
        logic [15:0] max_q;
    } reward_pkt_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_LO   = 3'd1,
        S_RD_HI   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_CALC    = 3'd4,
        S_WR_LO   = 3'd5,
        S_WR_HI   = 3'd6,
        S_DONE    = 3'd7
    } upd_state_e;

    localparam int ALU_WIDTH = 18;
    localparam logic signed [ALU_WIDTH-1:0] Q88_MAX = 18'sd32767;
    localparam logic signed [ALU_WIDTH-1:0] Q88_MIN = -18'sd32768;

    function automatic logic [15:0] sat_q88(input logic signed [ALU_WIDTH-1:0] v);
        if (v > Q88_MAX) begin
            return 16'h7FFF;
        end
        if (v < Q88_MIN) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/q_update_alu.sv
// Combinational Q-learning update: Q + ((R + gamma*maxQ - Q) * alpha), saturated to Q8.8.
module q_alu
    import q_update_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 1
) (
    input  logic [15:0] q_old,
    input  logic [15:0] reward,
    input  logic [15:0] max_q,
    output logic [15:0] q_upd
);

    logic signed [ALU_WIDTH-1:0] q_ext;
    logic signed [ALU_WIDTH-1:0] r_ext;
    logic signed [ALU_WIDTH-1:0] m_ext;
    logic signed [ALU_WIDTH-1:0] t_val;
    logic signed [ALU_WIDTH-1:0] d_val;
    logic signed [ALU_WIDTH-1:0] s_val;

    // 18 bits hold R + gamma*maxQ - Q without overflow; >>> floors toward -inf.
    always_comb begin
        q_ext = {{2{q_old[15]}}, q_old};
        r_ext = {{2{reward[15]}}, reward};
        m_ext = {{2{max_q[15]}}, max_q};
        t_val = m_ext - (m_ext >>> GAMMA_SHIFT);
        d_val = r_ext + t_val - q_ext;
        s_val = q_ext + (d_val >>> ALPHA_SHIFT);
        q_upd = sat_q88(s_val);
    end

endmodule

// File: rtl/q_update.sv
// Q-table update stage: latches a reward packet, reads Q(action) byte-wise from the
// shared memory, applies the update and writes it back while holding the bus grant.
module q_update #(
    parameter int                    WORD_WIDTH  = q_update_pkg::WORD_WIDTH,
    parameter int                    MEM_DEPTH   = q_update_pkg::MEM_DEPTH,
    parameter logic [WORD_WIDTH-1:0] QTABLE_BASE = 'h100,
    parameter int                    ALPHA_SHIFT = 2,
    parameter int                    GAMMA_SHIFT = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [q_update_pkg::PKT_WIDTH-1:0] reward_data,
    input  logic                               done_reward,
    output logic [WORD_WIDTH-1:0]              address,
    output logic                               wr_en,
    output logic [WORD_WIDTH-1:0]              mem_data_in,
    input  logic [WORD_WIDTH-1:0]              mem_data_out,
    output logic                               bus_grant,
    output logic [WORD_WIDTH-1:0]              q_new,
    output logic                               done_update
);

    import q_update_pkg::*;

    upd_state_e            state_q, state_d;
    reward_pkt_t           pkt_q, pkt_d;
    reward_pkt_t           pkt_in;
    logic [WORD_WIDTH-1:0] ea_q, ea_d;
    logic [WORD_WIDTH-1:0] ea_in;
    logic [WORD_WIDTH-1:0] ea_hi;
    logic [WORD_WIDTH-1:0] q_old_q, q_old_d;
    logic [WORD_WIDTH-1:0] address_q, address_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0] q_new_q, q_new_d;
    logic                  wr_en_q, wr_en_d;
    logic                  grant_q, grant_d;
    logic                  done_q, done_d;
    logic [15:0]           alu_result;
    logic                  unused_rsvd;

    function automatic logic [WORD_WIDTH-1:0] wrap_addr(input logic [31:0] a);
        logic [31:0] m;
        m = a % 32'(MEM_DEPTH);
        return m[WORD_WIDTH-1:0];
    endfunction

    assign pkt_in = reward_pkt_t'(reward_data);
    assign ea_in  = wrap_addr(32'(QTABLE_BASE) + {15'd0, pkt_in.action, 1'b0});
    assign ea_hi  = wrap_addr(32'(ea_q) + 32'd1);

    // Reserved packet fields and the unused upper read byte are carried but never consumed.
    assign unused_rsvd = ^{pkt_q.node_id, pkt_q.cluster_id, mem_data_out[WORD_WIDTH-1:8]};

    q_alu #(
        .ALPHA_SHIFT(ALPHA_SHIFT),
        .GAMMA_SHIFT(GAMMA_SHIFT)
    ) u_alu (
        .q_old (q_old_q),
        .reward(pkt_q.reward),
        .max_q (pkt_q.max_q),
        .q_upd (alu_result)
    );

    always_comb begin
        // NOTE: every _d gets a default first so this block can never infer a latch.
        state_d   = state_q;
        pkt_d     = pkt_q;
        ea_d      = ea_q;
        q_old_d   = q_old_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        q_new_d   = q_new_q;
        grant_d   = grant_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                address_d = '0;
                wdata_d   = '0;
                grant_d   = 1'b0;
                if (done_reward) begin
                    pkt_d     = pkt_in;
                    ea_d      = ea_in;
                    address_d = ea_in;
                    grant_d   = 1'b1;
                    state_d   = S_RD_LO;
                end
            end
            S_RD_LO: begin
                address_d = ea_hi;
                state_d   = S_RD_HI;
            end
            // Read data trails the address by one cycle, so each byte lands a state later.
            S_RD_HI: begin
                q_old_d[7:0] = mem_data_out[7:0];
                state_d      = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                q_old_d[15:8] = mem_data_out[7:0];
                state_d       = S_CALC;
            end
            S_CALC: begin
                q_new_d   = alu_result;
                address_d = ea_q;
                wdata_d   = {8'h00, alu_result[7:0]};
                wr_en_d   = 1'b1;
                state_d   = S_WR_LO;
            end
            S_WR_LO: begin
                address_d = ea_hi;
                wdata_d   = {8'h00, q_new_q[15:8]};
                wr_en_d   = 1'b1;
                state_d   = S_WR_HI;
            end
            S_WR_HI: begin
                address_d = '0;
                wdata_d   = '0;
                grant_d   = 1'b0;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                address_d = '0;
                wdata_d   = '0;
                grant_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pkt_q     <= '0;
            ea_q      <= '0;
            q_old_q   <= '0;
            address_q <= '0;
            wdata_q   <= '0;
            q_new_q   <= '0;
            grant_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every flop sample the same pre-edge values.
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            ea_q      <= ea_d;
            q_old_q   <= q_old_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            q_new_q   <= q_new_d;
            grant_q   <= grant_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
        end
    end

    assign address     = address_q;
    assign wr_en       = wr_en_q;
    assign mem_data_in = wdata_q;
    assign bus_grant   = grant_q;
    assign q_new       = q_new_q;
    assign done_update = done_q;

endmodule

// File: tb/tb_q_update.sv
// Self-checking bench for q_update: two instances (default table base and a table
// placed at the top of memory), each with its own byte-wide synchronous-read memory.
module tb_q_update;

    typedef struct {
        logic [15:0] ea;
        logic [15:0] q;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [79:0] reward_data;
    logic        done_reward_a, done_reward_w;
    logic [15:0] address_a, mem_data_in_a, mem_data_out_a, q_new_a;
    logic [15:0] address_w, mem_data_in_w, mem_data_out_w, q_new_w;
    logic        wr_en_a, bus_grant_a, done_update_a;
    logic        wr_en_w, bus_grant_w, done_update_w;

    logic [7:0]  mem_a [0:1023];
    logic [7:0]  mem_w [0:1023];
    logic        pre_we_a, pre_we_w;
    logic [9:0]  pre_addr;
    logic [7:0]  pre_data;
    logic [15:0] wlog_a [$];
    logic [15:0] wlog_w [$];
    exp_t        sb_q [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    q_update dut_a (
        .clock(clock), .reset(reset), .reward_data(reward_data), .done_reward(done_reward_a),
        .address(address_a), .wr_en(wr_en_a), .mem_data_in(mem_data_in_a),
        .mem_data_out(mem_data_out_a), .bus_grant(bus_grant_a), .q_new(q_new_a),
        .done_update(done_update_a)
    );

    q_update #(.QTABLE_BASE(16'h03FE)) dut_w (
        .clock(clock), .reset(reset), .reward_data(reward_data), .done_reward(done_reward_w),
        .address(address_w), .wr_en(wr_en_w), .mem_data_in(mem_data_in_w),
        .mem_data_out(mem_data_out_w), .bus_grant(bus_grant_w), .q_new(q_new_w),
        .done_update(done_update_w)
    );

    always @(posedge clock) begin
        mem_data_out_a <= {8'h00, mem_a[address_a[9:0]]};
        if (wr_en_a) begin
            mem_a[address_a[9:0]] <= mem_data_in_a[7:0];
            wlog_a.push_back(address_a);
        end else if (pre_we_a) begin
            mem_a[pre_addr] <= pre_data;
        end
    end

    always @(posedge clock) begin
        mem_data_out_w <= {8'h00, mem_w[address_w[9:0]]};
        if (wr_en_w) begin
            mem_w[address_w[9:0]] <= mem_data_in_w[7:0];
            wlog_w.push_back(address_w);
        end else if (pre_we_w) begin
            mem_w[pre_addr] <= pre_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int x, input int p);
        if (x >= 0) return x / p;
        return -((-x + p - 1) / p);
    endfunction

    // Reference update with alpha = 1/4, gamma = 1/2, computed in plain integers.
    function automatic logic [15:0] model_q(input logic [15:0] q, input logic [15:0] r,
                                            input logic [15:0] m);
        int qi, ri, mi, t, d, v;
        qi = int'($signed(q));
        ri = int'($signed(r));
        mi = int'($signed(m));
        t  = mi - floor_div(mi, 2);
        d  = ri + t - qi;
        v  = qi + floor_div(d, 4);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic logic [15:0] ea_of(input bit sel, input int action);
        int base;
        base = sel ? 'h3FE : 'h100;
        return 16'((base + 2 * action) % 1024);
    endfunction

    function automatic logic [15:0] addr_of(input bit sel);
        return sel ? address_w : address_a;
    endfunction
    function automatic logic grant_of(input bit sel);
        return sel ? bus_grant_w : bus_grant_a;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? done_update_w : done_update_a;
    endfunction
    function automatic logic [15:0] qnew_of(input bit sel);
        return sel ? q_new_w : q_new_a;
    endfunction
    function automatic logic [7:0] mem_rd(input bit sel, input int a);
        return sel ? mem_w[a % 1024] : mem_a[a % 1024];
    endfunction
    function automatic int wlog_size(input bit sel);
        return sel ? wlog_w.size() : wlog_a.size();
    endfunction
    function automatic logic [15:0] wlog_at(input bit sel, input int i);
        if (i >= wlog_size(sel)) return 16'hFFFF;
        return sel ? wlog_w[i] : wlog_a[i];
    endfunction

    task automatic set_req(input bit sel, input logic v);
        if (sel) done_reward_w = v;
        else     done_reward_a = v;
    endtask

    task automatic clear_wlog(input bit sel);
        if (sel) wlog_w.delete();
        else     wlog_a.delete();
    endtask

    task automatic preload(input bit sel, input int addr, input logic [15:0] v);
        pre_addr = 10'(addr % 1024);
        pre_data = v[7:0];
        if (sel) pre_we_w = 1'b1; else pre_we_a = 1'b1;
        @(negedge clock);
        pre_addr = 10'((addr + 1) % 1024);
        pre_data = v[15:8];
        @(negedge clock);
        pre_we_a = 1'b0;
        pre_we_w = 1'b0;
    endtask

    // Drive one request (at a negedge) and push what the DUT must produce for it.
    task automatic issue(input bit sel, input logic [15:0] action, input logic [15:0] r,
                         input logic [15:0] m, input logic [15:0] q_exp);
        exp_t e;
        e.ea = ea_of(sel, int'(action));
        e.q  = q_exp;
        sb_q.push_back(e);
        reward_data = {16'hA5A5, 16'h5A5A, r, action, m};
        set_req(sel, 1'b1);
    endtask

    task automatic finish_op(input bit sel, input string tag, input int busy_action);
        int          lat;
        exp_t        e;
        logic [15:0] ea1;
        lat = 0;
        e   = sb_q[0];
        ea1 = 16'((int'(e.ea) + 1) % 1024);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (i == 1) begin
                set_req(sel, 1'b0);
                check({tag, "_rd_addr_lo"}, 32'(addr_of(sel)), 32'(e.ea));
                check({tag, "_grant"}, 32'(grant_of(sel)), 32'd1);
            end
            if (i == 2) check({tag, "_rd_addr_hi"}, 32'(addr_of(sel)), 32'(ea1));
            if (busy_action >= 0 && i == 3) begin
                reward_data[31:16] = 16'(busy_action);
                set_req(sel, 1'b1);
            end
            if (busy_action >= 0 && i == 4) set_req(sel, 1'b0);
            if (done_of(sel)) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd7);
        e = sb_q.pop_front();
        check({tag, "_q_new"}, 32'(qnew_of(sel)), 32'(e.q));
        check({tag, "_grant_done"}, 32'(grant_of(sel)), 32'd0);
        check({tag, "_mem_lo"}, 32'(mem_rd(sel, int'(e.ea))), 32'(e.q[7:0]));
        check({tag, "_mem_hi"}, 32'(mem_rd(sel, int'(ea1))), 32'(e.q[15:8]));
        check({tag, "_n_writes"}, 32'(wlog_size(sel)), 32'd2);
        check({tag, "_wr_addr0"}, 32'(wlog_at(sel, 0)), 32'(e.ea));
        check({tag, "_wr_addr1"}, 32'(wlog_at(sel, 1)), 32'(ea1));
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done_of(sel)), 32'd0);
        clear_wlog(sel);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dones;
        int          prev_done;
        int          n_upd;
        logic [15:0] q_chain;
        logic [15:0] q_prev;
        exp_t        e;
        logic [15:0] pat_act [3];
        logic [15:0] pat_r   [3];
        logic [15:0] pat_m   [3];
        logic [15:0] pat_q   [3];

        reset = 1'b1;
        done_reward_a = 1'b0;
        done_reward_w = 1'b0;
        pre_we_a = 1'b0;
        pre_we_w = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        reward_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        check("rst_address", 32'(address_a), 32'd0);
        check("rst_wr_en", 32'(wr_en_a), 32'd0);
        check("rst_wdata", 32'(mem_data_in_a), 32'd0);
        check("rst_grant", 32'(bus_grant_a), 32'd0);
        check("rst_q_new", 32'(q_new_a), 32'd0);
        check("rst_done", 32'(done_update_a), 32'd0);
        check("rst_grant_w", 32'(bus_grant_w), 32'd0);

        // Worked example: Q[3]=1.0, R=2.0, maxQ=4.0 -> 1.75
        preload(0, 'h106, 16'h0100);
        issue(0, 16'd3, 16'h0200, 16'h0400, 16'h01C0);
        finish_op(0, "basic", -1);

        pat_act = '{16'd10, 16'd511, 16'd77};
        pat_r   = '{16'hFEB0, 16'h0000, 16'h1234};
        pat_m   = '{16'h0333, 16'hFC00, 16'h0001};
        pat_q   = '{16'h0080, 16'h0300, 16'hF000};
        for (int i = 0; i < 3; i++) begin
            preload(0, int'(ea_of(0, int'(pat_act[i]))), pat_q[i]);
            issue(0, pat_act[i], pat_r[i], pat_m[i], model_q(pat_q[i], pat_r[i], pat_m[i]));
            finish_op(0, $sformatf("pat%0d", i), -1);
        end

        preload(0, int'(ea_of(0, 20)), 16'h7F00);
        issue(0, 16'd20, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        finish_op(0, "sat_pos", -1);
        preload(0, int'(ea_of(0, 21)), 16'h8000);
        issue(0, 16'd21, 16'h8000, 16'h8000, 16'h8000);
        finish_op(0, "sat_neg", -1);

        // Table at 0x3FE: action 0 sits at the top, action 1 wraps to address 0.
        preload(1, 'h3FE, 16'h0010);
        issue(1, 16'd0, 16'h0100, 16'h0000, model_q(16'h0010, 16'h0100, 16'h0000));
        finish_op(1, "wrap0", -1);
        preload(1, 'h000, 16'hFF00);
        issue(1, 16'd1, 16'h0050, 16'hFF80, model_q(16'hFF00, 16'h0050, 16'hFF80));
        finish_op(1, "wrap1", -1);

        // Second request while busy must be dropped entirely.
        preload(0, int'(ea_of(0, 5)), 16'h0040);
        preload(0, int'(ea_of(0, 6)), 16'h1111);
        issue(0, 16'd5, 16'h0100, 16'h0200, model_q(16'h0040, 16'h0100, 16'h0200));
        finish_op(0, "busy", 6);
        dones = 0;
        repeat (12) begin
            @(negedge clock);
            if (done_update_a) dones++;
        end
        check("busy_no_second_done", 32'(dones), 32'd0);
        check("busy_no_extra_writes", 32'(wlog_a.size()), 32'd0);
        check("busy_other_lo", 32'(mem_rd(0, int'(ea_of(0, 6)))), 32'h11);
        check("busy_other_hi", 32'(mem_rd(0, int'(ea_of(0, 6)) + 1)), 32'h11);

        // Reset while the low byte is on the bus.
        preload(0, int'(ea_of(0, 7)), 16'h0A0B);
        issue(0, 16'd7, 16'h0300, 16'h0100, model_q(16'h0A0B, 16'h0300, 16'h0100));
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (i == 1) set_req(0, 1'b0);
        end
        check("midrst_in_wr_lo", 32'(wr_en_a), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wr_en_a), 32'd0);
        check("midrst_grant", 32'(bus_grant_a), 32'd0);
        check("midrst_address", 32'(address_a), 32'd0);
        check("midrst_wdata", 32'(mem_data_in_a), 32'd0);
        check("midrst_q_new", 32'(q_new_a), 32'd0);
        check("midrst_done", 32'(done_update_a), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        sb_q.delete();
        dones = 0;
        repeat (10) begin
            @(negedge clock);
            if (done_update_a) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        check("midrst_no_writes", 32'(wlog_a.size()), 32'd0);
        check("midrst_mem_lo", 32'(mem_rd(0, int'(ea_of(0, 7)))), 32'h0B);
        check("midrst_mem_hi", 32'(mem_rd(0, int'(ea_of(0, 7)) + 1)), 32'h0A);
        issue(0, 16'd7, 16'h0300, 16'h0100, model_q(16'h0A0B, 16'h0300, 16'h0100));
        finish_op(0, "midrst_retry", -1);

        // done_reward held for 20 cycles: three chained updates, 8 cycles apart.
        preload(0, int'(ea_of(0, 9)), 16'h0000);
        q_chain = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            q_chain = model_q(q_chain, 16'h0400, 16'h0400);
            e.ea = ea_of(0, 9);
            e.q  = q_chain;
            sb_q.push_back(e);
        end
        reward_data = {16'h0001, 16'h0002, 16'h0400, 16'd9, 16'h0400};
        set_req(0, 1'b1);
        prev_done = 0;
        n_upd = 0;
        q_prev = 16'h0000;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 20) set_req(0, 1'b0);
            if (done_update_a) begin
                if (n_upd == 0) check("b2b_first_latency", 32'(i), 32'd7);
                else            check("b2b_period", 32'(i - prev_done), 32'd8);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("b2b_q_new", 32'(q_new_a), 32'(e.q));
                    check("b2b_mem", {16'h0, mem_rd(0, int'(e.ea) + 1), mem_rd(0, int'(e.ea))},
                          32'(e.q));
                end else begin
                    check("b2b_unexpected_done", 32'(done_update_a), 32'd0);
                end
                check("b2b_monotonic", 32'($signed(q_new_a) > $signed(q_prev)), 32'd1);
                check("b2b_n_writes", 32'(wlog_a.size()), 32'd2);
                wlog_a.delete();
                q_prev = q_new_a;
                prev_done = i;
                n_upd++;
            end
        end
        check("b2b_update_count", 32'(n_upd), 32'd3);
        check("b2b_scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
